// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash read responder: decodes command 0x03 + 24-bit address and streams bytes on MISO.
// Define SPI_FLASH_RESPONDER_SEQ_READ_EN for continuous sequential reads across word boundaries.
module spi_flash_responder #(
    parameter int SS_IDX = 0,
    parameter int SS_NUM = 8,
    parameter int MEM_AW = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic [SS_NUM-1:0] spi_ss,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    // state  | meaning
    // IDLE   | not selected
    // CMD    | shifting in the command byte
    // ADDR   | shifting in the 24-bit address
    // FETCH  | waiting for the first data word
    // DATA   | streaming bytes on MISO
    // IGNORE | bad command or read exhausted, MISO held high
    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_FETCH, S_DATA, S_IGNORE
    } state_t;

    state_t state, state_nxt;

    logic [2:0]  sck_sync;
    logic [1:0]  ss_sync;
    logic [1:0]  mosi_sync;
    logic        sck_rise;
    logic        sck_fall;
    logic        sel;
    logic        mosi_bit;
    logic [4:0]  bit_cnt;
    logic [22:0] shift;
    logic [7:0]  cmd_byte;
    logic [23:0] addr_full;
    logic [21:0] word_addr;
    logic [31:0] data_buf;
    logic [4:0]  pos;
    logic        stale;
    logic        ack_take;
    logic        fetch_issue;
    logic        fetch_done;
    logic        data_fall;
`ifdef SPI_FLASH_RESPONDER_SEQ_READ_EN
    logic [31:0] next_buf;
`else
    logic        done;
`endif
    logic        unused_ss;

    assign unused_ss = ^spi_ss;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sck_sync  <= {sck_sync[1:0], spi_sck};
            ss_sync   <= {ss_sync[0], spi_ss[SS_IDX]};
            mosi_sync <= {mosi_sync[0], spi_mosi};
        end
    end

    assign sck_rise  = sck_sync[1] & ~sck_sync[2];
    assign sck_fall  = ~sck_sync[1] & sck_sync[2];
    assign sel       = ~ss_sync[1];
    assign mosi_bit  = mosi_sync[1];
    assign busy      = sel;
    assign cmd_byte  = {shift[6:0], mosi_bit};
    assign addr_full = {shift, mosi_bit};
    assign ack_take  = mem_req & mem_ack;
    assign mem_addr  = MEM_AW'({word_addr, 2'b00});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!sel) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: state_nxt = S_CMD;
                S_CMD: begin
                    if (sck_rise && bit_cnt == 5'd7) begin
                        state_nxt = (cmd_byte == 8'h03) ? S_ADDR : S_IGNORE;
                    end
                end
                S_ADDR: begin
                    if (fetch_issue) state_nxt = S_FETCH;
                end
                S_FETCH: begin
                    if (fetch_done) state_nxt = S_DATA;
                end
`ifndef SPI_FLASH_RESPONDER_SEQ_READ_EN
                S_DATA: begin
                    if (data_fall && done) state_nxt = S_IGNORE;
                end
`endif
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        cmd_err     = 1'b0;
        fetch_issue = 1'b0;
        fetch_done  = 1'b0;
        data_fall   = 1'b0;
        if (sel) begin
            case (state)
                S_CMD:   cmd_err     = sck_rise && bit_cnt == 5'd7 && cmd_byte != 8'h03;
                S_ADDR:  fetch_issue = sck_rise && bit_cnt == 5'd23;
                S_FETCH: fetch_done  = ack_take && !stale;
                S_DATA:  data_fall   = sck_fall;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            shift     <= '0;
            word_addr <= '0;
            data_buf  <= '0;
            pos       <= '0;
            stale     <= 1'b0;
            mem_req   <= 1'b0;
            spi_miso  <= 1'b1;
`ifdef SPI_FLASH_RESPONDER_SEQ_READ_EN
            next_buf  <= '0;
`else
            done      <= 1'b0;
`endif
        end else begin
            // A fetch left pending by a deselect completes on the port but its data is dropped.
            if (ack_take) begin
                mem_req <= 1'b0;
                stale   <= 1'b0;
            end else if (!sel && mem_req) begin
                stale <= 1'b1;
            end

            if (!sel) begin
                bit_cnt  <= '0;
                spi_miso <= 1'b1;
`ifndef SPI_FLASH_RESPONDER_SEQ_READ_EN
                done     <= 1'b0;
`endif
            end

            if ((state == S_CMD || state == S_ADDR) && sel && sck_rise) begin
                shift   <= addr_full[22:0];
                bit_cnt <= (state == S_CMD && bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
            end

            if (fetch_issue) begin
                pos <= {addr_full[1:0], 3'b000};
                if (!mem_req) begin
                    mem_req   <= 1'b1;
                    word_addr <= addr_full[23:2];
                end
            end

            if (fetch_done) begin
                data_buf <= mem_rdata;
`ifndef SPI_FLASH_RESPONDER_SEQ_READ_EN
                done     <= 1'b0;
`endif
            end

`ifdef SPI_FLASH_RESPONDER_SEQ_READ_EN
            if (state == S_DATA && sel && ack_take && !stale) begin
                next_buf <= mem_rdata;
            end
            // pos = {byte pointer, bit index}; prefetch on entering byte 3, swap after its last bit.
            if (data_fall) begin
                spi_miso <= data_buf[{pos[4:3], ~pos[2:0]}];
                pos      <= pos + 5'd1;
                if (pos == 5'd24 && !mem_req) begin
                    mem_req   <= 1'b1;
                    word_addr <= word_addr + 22'd1;
                end
                if (pos == 5'd31) begin
                    data_buf <= next_buf;
                end
            end
`else
            if (data_fall) begin
                if (done) begin
                    spi_miso <= 1'b1;
                end else begin
                    spi_miso <= data_buf[{pos[4:3], ~pos[2:0]}];
                    pos      <= pos + 5'd1;
                    if (pos == 5'd31) done <= 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomised read transactions against a byte-addressed memory model; expected MISO bytes and
// fetch addresses come from the read rules, not from the responder's internals.
module tb_spi_flash_responder;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck;
    logic        mosi;
    logic        miso;
    logic [7:0]  ss;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        cmd_err;

    int vec_cnt = 0;
    int err_cnt = 0;
    int err_pulses = 0;
    int lat_cur = 2;
    bit ack_en = 1'b1;
    int hdr_bad = 0;

    logic [7:0]  rx_q[$];
    logic [23:0] fetch_q[$];
    logic [31:0] mem_ovr[int];

    always #5 clk = ~clk;

    spi_flash_responder dut (
        .clock     (clk),
        .reset     (rst),
        .spi_sck   (sck),
        .spi_ss    (ss),
        .spi_mosi  (mosi),
        .spi_miso  (miso),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [23:0] a);
        logic [23:0] w;
        w = {a[23:2], 2'b00};
        if (mem_ovr.exists(int'(w))) return mem_ovr[int'(w)];
        return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        logic [31:0] wd;
        wd = mem_word(a);
        return wd[8*int'(a[1:0]) +: 8];
    endfunction

    always @(negedge clk) begin
        if (cmd_err === 1'b1) err_pulses++;
    end

    // Memory side: accept a request, answer after lat_cur cycles with a one-cycle ack.
    initial begin : mem_side
        logic [23:0] a;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (ack_en && rst === 1'b0 && mem_req === 1'b1) begin
                a = mem_addr;
                fetch_q.push_back(a);
                repeat (lat_cur - 1) @(negedge clk);
                chk("mem_addr_stable", 32'(mem_addr), 32'(a));
                mem_ack   = 1'b1;
                mem_rdata = mem_word(a);
                @(negedge clk);
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    initial begin : watchdog
        #800_000;
        $display("FAIL watchdog: run still active at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic spi_xfer(input logic [7:0] cmd, input logic [23:0] addr,
                            input int nbytes, input int stop_at);
        logic [31:0] hdr;
        logic [7:0]  cur;
        int          total;
        hdr     = {cmd, addr};
        cur     = '0;
        total   = 32 + 8 * nbytes;
        hdr_bad = 0;
        rx_q.delete();
        ss = 8'hFE;
        repeat (4) @(negedge clk);
        chk("busy_selected", 32'(busy), 32'd1);
        for (int i = 0; i < total && i < stop_at; i++) begin
            mosi = (i < 32) ? hdr[31 - i] : 1'($urandom_range(0, 1));
            repeat (HALF) @(negedge clk);
            if (i >= 32) cur = {cur[6:0], miso};
            else if (miso !== 1'b1) hdr_bad++;
            sck = 1'b1;
            if (i >= 32 && ((i - 32) % 8) == 7) rx_q.push_back(cur);
            repeat ((i == 31) ? 4 * HALF : HALF) @(negedge clk);
            sck = 1'b0;
        end
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_release();
        ss   = 8'hFF;
        mosi = 1'b0;
        repeat (30) @(negedge clk);
        chk("busy_released", 32'(busy), 32'd0);
    endtask

    task automatic run_read(input logic [23:0] addr, input int nbytes, input int lat);
        int          base;
        logic [23:0] a;
        logic [7:0]  e;
        logic [23:0] f[$];
        lat_cur = lat;
        base    = fetch_q.size();
        spi_xfer(8'h03, addr, nbytes, 1 << 20);
        spi_release();
        chk("hdr_miso_high", 32'(hdr_bad), 32'd0);
        f.push_back({addr[23:2], 2'b00});
        for (int k = 0; k < nbytes; k++) begin
            a = addr + 24'(k);
`ifdef SPI_FLASH_RESPONDER_SEQ_READ_EN
            e = mem_byte(a);
            if (a[1:0] == 2'd3) f.push_back(a + 24'd1);
`else
            e = (k < 4 - int'(addr[1:0])) ? mem_byte(a) : 8'hFF;
`endif
            chk("rx_byte", (k < rx_q.size()) ? 32'(rx_q[k]) : 32'hDEAD, 32'(e));
        end
        chk("fetch_count", 32'(fetch_q.size() - base), 32'(f.size()));
        for (int j = 0; j < f.size() && base + j < fetch_q.size(); j++) begin
            chk("fetch_addr", 32'(fetch_q[base + j]), 32'(f[j]));
        end
    endtask

    initial begin : main
        int          base;
        int          pulses0;
        logic [23:0] raddr;
        int          nb;
        rst  = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        ss   = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_miso", 32'(miso), 32'd1);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_err", 32'(cmd_err), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        ss = 8'hFD;
        repeat (6) @(negedge clk);
        chk("busy_other_ss", 32'(busy), 32'd0);
        ss = 8'hFF;
        repeat (4) @(negedge clk);

        mem_ovr[32'h100] = 32'h4433_2211;
        run_read(24'h000100, 4, 2);
        run_read(24'h000102, 4, 2);

        pulses0 = err_pulses;
        base    = fetch_q.size();
        spi_xfer(8'h9F, 24'h000100, 4, 1 << 20);
        spi_release();
        chk("bad_cmd_err_pulses", 32'(err_pulses - pulses0), 32'd1);
        chk("bad_cmd_no_fetch", 32'(fetch_q.size() - base), 32'd0);
        chk("bad_cmd_hdr_miso", 32'(hdr_bad), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("bad_cmd_miso", (k < rx_q.size()) ? 32'(rx_q[k]) : 32'hDEAD, 32'hFF);
        end

        base = fetch_q.size();
        spi_xfer(8'h03, 24'h000000, 0, 20);
        spi_release();
        chk("abort_no_fetch", 32'(fetch_q.size() - base), 32'd0);
        run_read(24'h000000, 4, 3);

        run_read(24'hFFFFFC, 8, 2);

        ack_en = 1'b0;
        spi_xfer(8'h03, 24'h000200, 1, 32);
        chk("req_before_reset", 32'(mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("reset_req", 32'(mem_req), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_miso", 32'(miso), 32'd1);
        chk("reset_addr", 32'(mem_addr), 32'd0);
        ss = 8'hFF;
        repeat (4) @(negedge clk);
        rst    = 1'b0;
        ack_en = 1'b1;
        repeat (4) @(negedge clk);
        run_read(24'h000200, 4, 1);

        for (int n = 0; n < 10; n++) begin
            raddr = 24'($urandom);
            if (n % 4 == 0) raddr[23:4] = '1;
`ifdef SPI_FLASH_RESPONDER_SEQ_READ_EN
            nb = $urandom_range(1, 10);
`else
            nb = $urandom_range(1, 6);
`endif
            run_read(raddr, nb, $urandom_range(1, 4));
        end

        chk("cmd_err_total", 32'(err_pulses), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
